// File: rtl/grf_pkg.sv
// Shared constants and helpers for the general register file with pending-writer scoreboard.
// Latency: n/a (package only: constants and a combinational helper function).
// Backpressure: n/a.
// Contents: default widths (GRF_DATA_W, GRF_ADDR_W, GRF_CNT_W, GRF_NUM_REGS), ZERO_REG index,
//           win_port() which picks the highest-index write port hitting an address.
package grf_pkg;

  localparam int GRF_DATA_W   = 32;
  localparam int GRF_ADDR_W   = 5;
  localparam int GRF_CNT_W    = 2;
  localparam int GRF_NUM_REGS = 2 ** GRF_ADDR_W;

  // Hardwired-zero register index.
  localparam int ZERO_REG = 0;

  // Upper bound on write ports the helper below can arbitrate.
  localparam int MAX_WR = 8;
  localparam int WIN_W  = 3;

  // hit[k] = write port k is enabled and targets the address of interest.
  // Returns the highest set index (higher port index has priority); 0 when
  // nothing hits, so callers must also check |hit.
  function automatic logic [WIN_W-1:0] win_port(input logic [MAX_WR-1:0] hit);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (hit[i]) w = WIN_W'(i);
    end
    return w;
  endfunction

endpackage

// File: rtl/grf_pending_ctr.sv
// Per-register saturating pending-writer counter (+1 alloc, -0..NUM_WR releases per cycle).
// Latency: cnt_o updates one cycle after inc_i/dec_i; nonzero_o is combinational.
// Backpressure: none here; the caller must only raise inc_i when cnt_o is below its maximum.
// Ports: clk, reset (sync, active-high), inc_i (one new allocation), dec_i (releases this cycle),
//        cnt_o (current count), nonzero_o (count still nonzero once this cycle's releases apply).
module grf_pending_ctr #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic [DEC_W-1:0] dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nonzero_o
);

  localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((2 ** CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum, dec_ext, diff;

  always_comb begin
    sum     = SUM_W'(cnt_q) + SUM_W'(inc_i);
    dec_ext = SUM_W'(dec_i);
    diff    = sum - dec_ext;
    cnt_d   = cnt_q;
    // Releases beyond what is pending are dropped: floor at zero.
    if (dec_ext >= sum) begin
      cnt_d = '0;
    end else if (diff > CNT_MAX) begin
      cnt_d = '1;
    end else begin
      cnt_d = CNT_W'(diff);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A same-cycle alloc is deliberately excluded: a reader only becomes busy
  // from the cycle after the claim.
  assign nonzero_o = SUM_W'(cnt_q) > dec_ext;
  assign cnt_o     = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (dec_ext <= sum)
        else $warning("grf_pending_ctr: release with nothing pending, dropped");
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// Register file (NUM_RD read / NUM_WR write, write-through bypass) with per-register pending-writer scoreboard.
// Latency: reads and bypass combinational (0 cycles); writes, allocs and releases take effect at the next posedge.
// Backpressure: alloc_ok=0 when the claimed register's counter is full; the issuer must stall, the claim is ignored.
// Ports: clk, reset (sync, active-high); wr_en/wr_addr/wr_data/wr_release/wr_pc per write port (packed, port k at
//        [k*W +: W], higher k wins); rd_addr -> rd_data/rd_busy per read port; alloc_en/alloc_addr -> alloc_ok.
// Optional: define GRF_TRACE_EN to print each committed write as "@<pc>: $<reg> <= <data>"; wr_pc is unused otherwise.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int CNT_W  = GRF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        wr_release,
  input  logic [NUM_WR*32-1:0]     wr_pc,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_ok
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int DEC_W    = $clog2(NUM_WR + 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // ---------------------------------------------------------------- storage
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  // Ports applied in ascending order so the highest-index port wins a clash.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
        mem_d[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // ------------------------------------------------------------ scoreboard
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            busy;

  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  assign alloc_ok = (alloc_addr == ZERO_ADDR) || (cnt[alloc_addr] != CNT_MAX);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ctr
    logic             inc_r;
    logic [DEC_W-1:0] dec_r;

    assign inc_r = alloc_en && alloc_ok && (alloc_addr == ADDR_W'(r));

    // Number of write ports retiring an allocation of this register.
    always_comb begin
      dec_r = '0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_release[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          dec_r = dec_r + DEC_W'(1);
        end
      end
    end

    grf_pending_ctr #(
      .CNT_W (CNT_W),
      .DEC_W (DEC_W)
    ) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .inc_i     (inc_r),
      .dec_i     (dec_r),
      .cnt_o     (cnt[r]),
      .nonzero_o (busy[r])
    );
  end

  // ------------------------------------------------------------ read ports
  logic [MAX_WR-1:0] rd_hit;
  logic [WIN_W-1:0]  rd_win;
  logic [ADDR_W-1:0] ra;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_hit  = '0;
    rd_win  = '0;
    ra      = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      ra     = rd_addr[j*ADDR_W +: ADDR_W];
      rd_hit = '0;
      for (int k = 0; k < NUM_WR; k++) begin
        rd_hit[k] = wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ra);
      end
      rd_win = win_port(rd_hit);
      rd_data[j*DATA_W +: DATA_W] = mem_q[ra];
      // Same-cycle write is forwarded so ID never sees stale data.
      for (int k = 0; k < NUM_WR; k++) begin
        if ((|rd_hit) && (rd_win == WIN_W'(k))) begin
          rd_data[j*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
        end
      end
      if (ra == ZERO_ADDR) begin
        rd_data[j*DATA_W +: DATA_W] = '0;
      end
      rd_busy[j] = busy[ra];
    end
  end

  // ----------------------------------------------------------------- trace
`ifdef GRF_TRACE_EN
  logic [NUM_WR-1:0] commit;
  logic [MAX_WR-1:0] tr_hit;

  // A port commits only if no higher port writes the same register.
  always_comb begin
    commit = '0;
    tr_hit = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      tr_hit = '0;
      for (int i = 0; i < NUM_WR; i++) begin
        tr_hit[i] = wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W]);
      end
      commit[k] = wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] != ZERO_ADDR)
                  && (win_port(tr_hit) == WIN_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (commit[k]) begin
          $display("@%h: $%0d <= %h", wr_pc[k*32 +: 32], wr_addr[k*ADDR_W +: ADDR_W],
                   wr_data[k*DATA_W +: DATA_W]);
        end
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
module tb_grf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int CMAX = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    wr_release;
  logic [NW*32-1:0] wr_pc;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             alloc_ok;

  always #5 clk = ~clk;

  grf_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_release (wr_release),
    .wr_pc      (wr_pc),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_ok   (alloc_ok)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------ behavioural model
  bit          model_live = 1'b0;
  logic [31:0] m_reg [32];
  int          m_cnt [32];

  function automatic int wa(input int k);
    return int'(wr_addr[k*AW +: AW]);
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_reg[a];
    for (int k = 0; k < NW; k++)
      if (wr_en[k] && wa(k) == a) v = wr_data[k*DW +: DW];
    return v;
  endfunction

  function automatic int m_dec(input int a);
    int n = 0;
    for (int k = 0; k < NW; k++)
      if (wr_en[k] && wr_release[k] && wa(k) == a) n++;
    return n;
  endfunction

  function automatic bit m_busy(input int a);
    return (a != 0) && ((m_cnt[a] - m_dec(a)) > 0);
  endfunction

  function automatic bit m_aok();
    int a = int'(alloc_addr);
    return (a == 0) || (m_cnt[a] != CMAX);
  endfunction

  task automatic model_tick();
    int n [32];
    bit ok;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r] = 32'h0;
        m_cnt[r] = 0;
      end
      model_live = 1'b1;
    end else if (model_live) begin
      ok = m_aok();
      for (int r = 1; r < 32; r++) begin
        n[r] = m_cnt[r] - m_dec(r);
        if (alloc_en && ok && int'(alloc_addr) == r) n[r] = n[r] + 1;
        if (n[r] < 0) n[r] = 0;
      end
      for (int k = 0; k < NW; k++)
        if (wr_en[k] && wa(k) != 0) m_reg[wa(k)] = wr_data[k*DW +: DW];
      for (int r = 1; r < 32; r++) m_cnt[r] = n[r];
    end
  endtask

  // Compare process: all outputs are combinational, check before every edge.
  always @(negedge clk) begin
    if (model_live && !reset) begin
      for (int j = 0; j < NR; j++) begin
        chk($sformatf("rd_data%0d", j), rd_data[j*DW +: DW], m_read(int'(rd_addr[j*AW +: AW])));
        chk($sformatf("rd_busy%0d", j), 32'(rd_busy[j]), 32'(m_busy(int'(rd_addr[j*AW +: AW]))));
      end
      chk("alloc_ok", 32'(alloc_ok), 32'(m_aok()));
    end
  end

  // ------------------------------------------------ stimulus helpers
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d, input bit rel);
    wr_en[k]              = 1'b1;
    wr_addr[k*AW +: AW]   = a;
    wr_data[k*DW +: DW]   = d;
    wr_release[k]         = rel;
    wr_pc[k*32 +: 32]     = 32'h0000_1000 + 32'(k * 4);
  endtask

  task automatic clr_wr();
    wr_en      = '0;
    wr_release = '0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // ------------------------------------------------ directed sequence
  initial begin
    reset = 1'b1;
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_release = '0; wr_pc = '0;
    rd_addr = '0; alloc_en = 1'b0; alloc_addr = '0;

    // Reset, with a write and an alloc that must both be ignored.
    wr(0, 5'd5, 32'h1234, 1'b0);
    alloc_en = 1'b1; alloc_addr = 5'd5;
    tick();
    tick();
    reset = 1'b0;
    clr_wr();
    alloc_en = 1'b0;

    for (int r = 1; r < 32; r++) begin
      rd(5'(r), 5'(r));
      alloc_addr = 5'(r);
      settle();
      chk("reset_rd0", rd_data[31:0], 32'h0);
      chk("reset_rd1", rd_data[63:32], 32'h0);
      chk("reset_busy", 32'(rd_busy), 32'h0);
      chk("reset_aok", 32'(alloc_ok), 32'h1);
      tick();
    end

    // Same-cycle bypass then stored value.
    wr(0, 5'd8, 32'hDEAD_BEEF, 1'b0);
    rd(5'd8, 5'd0);
    settle();
    chk("bypass_r8", rd_data[31:0], 32'hDEAD_BEEF);
    tick();
    clr_wr();
    settle();
    chk("stored_r8", rd_data[31:0], 32'hDEAD_BEEF);
    tick();

    // Write-port conflict: port1 wins.
    wr(0, 5'd3, 32'h11, 1'b0);
    wr(1, 5'd3, 32'h22, 1'b0);
    rd(5'd3, 5'd3);
    settle();
    chk("conflict_byp0", rd_data[31:0], 32'h22);
    chk("conflict_byp1", rd_data[63:32], 32'h22);
    tick();
    clr_wr();
    settle();
    chk("conflict_st", rd_data[31:0], 32'h22);
    tick();

    // r0 is hardwired to zero.
    wr(0, 5'd0, 32'hFFFF, 1'b0);
    rd(5'd0, 5'd0);
    settle();
    chk("r0_byp", rd_data[31:0], 32'h0);
    tick();
    clr_wr();
    settle();
    chk("r0_st", rd_data[31:0], 32'h0);
    tick();

    // Fill r4's counter to max, fourth claim refused.
    rd(5'd4, 5'd0);
    alloc_en = 1'b1; alloc_addr = 5'd4;
    for (int i = 0; i < 3; i++) tick();
    settle();
    chk("r4_full_aok", 32'(alloc_ok), 32'h0);
    chk("r4_full_busy", 32'(rd_busy[0]), 32'h1);
    tick();
    alloc_en = 1'b0;
    wr(0, 5'd4, 32'h44, 1'b1);
    settle();
    chk("r4_rel_busy", 32'(rd_busy[0]), 32'h1);
    tick();
    clr_wr();
    settle();
    chk("r4_after_aok", 32'(alloc_ok), 32'h1);
    chk("r4_after_busy", 32'(rd_busy[0]), 32'h1);
    tick();
    wr(0, 5'd4, 32'h45, 1'b1);
    wr(1, 5'd4, 32'h46, 1'b1);
    settle();
    chk("r4_dual_rel_busy", 32'(rd_busy[0]), 32'h0);
    chk("r4_dual_rel_dat", rd_data[31:0], 32'h46);
    tick();
    clr_wr();

    // Last writer releasing: not busy, data bypassed.
    alloc_en = 1'b1; alloc_addr = 5'd6;
    rd(5'd6, 5'd6);
    tick();
    alloc_en = 1'b0;
    settle();
    chk("r6_busy_pre", 32'(rd_busy[0]), 32'h1);
    wr(0, 5'd6, 32'h77, 1'b1);
    settle();
    chk("r6_rel_busy", 32'(rd_busy[0]), 32'h0);
    chk("r6_rel_dat", rd_data[31:0], 32'h77);
    tick();
    // Excess release at zero: count must stay at zero.
    wr(0, 5'd6, 32'h78, 1'b1);
    tick();
    clr_wr();
    settle();
    chk("r6_floor_busy", 32'(rd_busy[0]), 32'h0);
    chk("r6_floor_aok", 32'(alloc_ok), 32'h1);
    alloc_en = 1'b1;
    tick();
    alloc_en = 1'b0;
    settle();
    chk("r6_realloc_busy", 32'(rd_busy[0]), 32'h1);
    wr(1, 5'd6, 32'h79, 1'b1);
    tick();
    clr_wr();

    // Alloc and release on r9 in one cycle nets out.
    alloc_en = 1'b1; alloc_addr = 5'd9;
    rd(5'd9, 5'd9);
    tick();
    wr(0, 5'd9, 32'h99, 1'b1);
    settle();
    chk("r9_net_busy_now", 32'(rd_busy[0]), 32'h0);
    tick();
    clr_wr();
    alloc_en = 1'b0;
    settle();
    chk("r9_net_busy_next", 32'(rd_busy[0]), 32'h1);
    chk("r9_net_dat", rd_data[31:0], 32'h99);
    tick();

    // Reset clears a pending count.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("r9_rst_busy", 32'(rd_busy[0]), 32'h0);
    chk("r9_rst_dat", rd_data[31:0], 32'h0);
    chk("r9_rst_aok", 32'(alloc_ok), 32'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
